// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Grants are latched at arbitration; completion is a one-cycle done pulse to the owner.
module apb_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              write0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              done0_o,

    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic              write1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              done1_o,

    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,

    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic              pready_i,
    input  logic              pslverr_i,
    input  logic [DATA_W-1:0] prdata_i
);

    localparam int              CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q;
    logic               last_grant_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_access;
    logic               timed_out;
    logic               complete;
    logic               other_req;
    logic               grant_valid;
    logic               grant_id;

    assign in_access = (state_q == ST_ACCESS);
    assign timed_out = in_access && !pready_i && (cnt_q == CNT_LAST);
    assign complete  = in_access && (pready_i || timed_out);

    // The owner's request is consumed at completion, so only the other side may chain.
    assign other_req = owner_q ? req0_i : req1_i;

    // NOTE: defaults are assigned first so every path drives every signal and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    grant_valid = 1'b1;
                    grant_id    = (req0_i && req1_i) ? ~last_grant_q : req1_i;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (complete) begin
                    if (other_req) begin
                        grant_valid = 1'b1;
                        grant_id    = ~owner_q;
                        state_d     = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            pwrite_o     <= 1'b0;
            paddr_o      <= '0;
            pwdata_o     <= '0;
        end else begin
            state_q <= state_d;

            if (grant_valid) begin
                owner_q      <= grant_id;
                last_grant_q <= grant_id;
                paddr_o      <= grant_id ? addr1_i  : addr0_i;
                pwrite_o     <= grant_id ? write1_i : write0_i;
                pwdata_o     <= grant_id ? wdata1_i : wdata0_i;
            end

            if (state_q == ST_SETUP) begin
                cnt_q <= '0;
            end else if (in_access && !pready_i) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign psel_o    = (state_q != ST_IDLE);
    assign penable_o = in_access;

    assign done0_o = complete && !owner_q;
    assign done1_o = complete &&  owner_q;

    // Slave response only matters on a real handshake; a timeout forces an error with no data.
    assign err_o   = complete && (timed_out || pslverr_i);
    assign rdata_o = (complete && pready_i && !pwrite_o) ? prdata_i : '0;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_apb_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    localparam logic [31:0] A0 = 32'hDEAD_CAFE;
    localparam logic [31:0] D0 = 32'h0BAD_F00D;
    localparam logic [31:0] A1 = 32'h0000_1000;
    localparam logic [31:0] D1 = 32'hDEAD_CAFF;

    logic              clk;
    logic              reset_n;
    logic              req0_i, req1_i;
    logic [ADDR_W-1:0] addr0_i, addr1_i;
    logic              write0_i, write1_i;
    logic [DATA_W-1:0] wdata0_i, wdata1_i;
    logic              done0_o, done1_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pready_i, pslverr_i;
    logic [DATA_W-1:0] prdata_i;

    apb_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0_i   (req0_i),
        .addr0_i  (addr0_i),
        .write0_i (write0_i),
        .wdata0_i (wdata0_i),
        .done0_o  (done0_o),
        .req1_i   (req1_i),
        .addr1_i  (addr1_i),
        .write1_i (write1_i),
        .wdata1_i (wdata1_i),
        .done1_o  (done1_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .psel_o   (psel_o),
        .penable_o(penable_o),
        .pwrite_o (pwrite_o),
        .paddr_o  (paddr_o),
        .pwdata_o (pwdata_o),
        .pready_i (pready_i),
        .pslverr_i(pslverr_i),
        .prdata_i (prdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        bit          req0, req1, scr, pready, pslverr;
        logic [31:0] prdata;
        bit          psel, penable, done0, done1, err;
        logic [31:0] rdata;
        logic [31:0] paddr;
        bit          pwrite;
        logic [31:0] pwdata;
    } vec_t;

    // in_b = {req0, req1, scramble payload, pready, pslverr}; ex_b = {psel, penable, done0, done1, err}
    function automatic vec_t mk(input bit [4:0] in_b, input logic [31:0] prd, input bit [4:0] ex_b,
                                input logic [31:0] rd, input logic [31:0] pa, input bit pw,
                                input logic [31:0] pwd);
        vec_t v;
        {v.req0, v.req1, v.scr, v.pready, v.pslverr} = in_b;
        v.prdata = prd;
        {v.psel, v.penable, v.done0, v.done1, v.err} = ex_b;
        v.rdata  = rd;
        v.paddr  = pa;
        v.pwrite = pw;
        v.pwdata = pwd;
        return v;
    endfunction

    // Nominal payloads, or garbage ones to prove only grant-time values matter.
    task automatic set_payload(input bit scr);
        addr0_i  = scr ? ~A0 : A0;
        wdata0_i = scr ? ~D0 : D0;
        write0_i = scr;
        addr1_i  = scr ? ~A1 : A1;
        wdata1_i = scr ? ~D1 : D1;
        write1_i = !scr;
    endtask

    task automatic idle_inputs();
        req0_i    = 1'b0;
        req1_i    = 1'b0;
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = '0;
        set_payload(1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check("reset psel",    psel_o,    1'b0);
        check("reset penable", penable_o, 1'b0);
        check("reset pwrite",  pwrite_o,  1'b0);
        check("reset paddr",   paddr_o,   32'h0);
        check("reset pwdata",  pwdata_o,  32'h0);
        check("reset dones",   {done0_o, done1_o}, 2'b00);
        check("reset rdata",   rdata_o,   32'h0);
        check("reset err",     err_o,     1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // First completion within a bounded window: 0/1 = owner, -1 = no completion.
    task automatic first_done(output int who);
        who = -1;
        for (int c = 0; c < 10 && who < 0; c++) begin
            @(negedge clk);
            #1;
            if (done0_o) who = 0;
            else if (done1_o) who = 1;
        end
    endtask

    vec_t vecs[13];

    // Reference model state (transaction view: granted?, in access phase?, cycles waited)
    bit          m_busy, m_acc, m_owner, m_last, m_wr;
    int          m_wait;
    logic [31:0] m_addr, m_wdata;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          who;
        int          own[4];
        int          when[4];
        int          dn, gaps, both, acc, hang;
        bit          seen, finish, cand0, cand1, w;
        bit          e_d0, e_d1, e_err;
        logic [31:0] e_rd;

        reset_n = 1'b1;
        idle_inputs();
        apply_reset();

        // ---------------- directed vector table ----------------
        vecs[0]  = mk(5'b10000, 32'h0,         5'b00000, 32'h0,         32'h0, 1'b0, 32'h0);
        vecs[1]  = mk(5'b10111, 32'h1234_5678, 5'b10000, 32'h0,         A0,    1'b0, D0);
        vecs[2]  = mk(5'b10010, 32'h1234_5678, 5'b11100, 32'h1234_5678, A0,    1'b0, D0);
        vecs[3]  = mk(5'b01000, 32'h0,         5'b00000, 32'h0,         32'h0, 1'b0, 32'h0);
        vecs[4]  = mk(5'b01000, 32'h0,         5'b10000, 32'h0,         A1,    1'b1, D1);
        vecs[5]  = mk(5'b01100, 32'h0,         5'b11000, 32'h0,         A1,    1'b1, D1);
        vecs[6]  = mk(5'b01101, 32'hFFFF_FFFF, 5'b11000, 32'h0,         A1,    1'b1, D1);
        vecs[7]  = mk(5'b01100, 32'h0,         5'b11000, 32'h0,         A1,    1'b1, D1);
        vecs[8]  = mk(5'b01011, 32'hFFFF_FFFF, 5'b11011, 32'h0,         A1,    1'b1, D1);
        vecs[9]  = mk(5'b10000, 32'h0,         5'b00000, 32'h0,         32'h0, 1'b0, 32'h0);
        vecs[10] = mk(5'b10000, 32'h0,         5'b10000, 32'h0,         A0,    1'b0, D0);
        vecs[11] = mk(5'b10010, 32'hA5A5_A5A5, 5'b11100, 32'hA5A5_A5A5, A0,    1'b0, D0);
        vecs[12] = mk(5'b00000, 32'h0,         5'b00000, 32'h0,         32'h0, 1'b0, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            req0_i    = vecs[i].req0;
            req1_i    = vecs[i].req1;
            set_payload(vecs[i].scr);
            pready_i  = vecs[i].pready;
            pslverr_i = vecs[i].pslverr;
            prdata_i  = vecs[i].prdata;
            #1;
            check($sformatf("vec%0d psel", i),    psel_o,    vecs[i].psel);
            check($sformatf("vec%0d penable", i), penable_o, vecs[i].penable);
            check($sformatf("vec%0d done0", i),   done0_o,   vecs[i].done0);
            check($sformatf("vec%0d done1", i),   done1_o,   vecs[i].done1);
            check($sformatf("vec%0d err", i),     err_o,     vecs[i].err);
            check($sformatf("vec%0d rdata", i),   rdata_o,   vecs[i].rdata);
            if (vecs[i].psel) begin
                check($sformatf("vec%0d paddr", i),  paddr_o,  vecs[i].paddr);
                check($sformatf("vec%0d pwrite", i), pwrite_o, vecs[i].pwrite);
                check($sformatf("vec%0d pwdata", i), pwdata_o, vecs[i].pwdata);
            end
        end

        // ---------------- contention: alternating back-to-back grants ----------------
        apply_reset();
        dn = 0; gaps = 0; both = 0;
        for (int k = 0; k < 4; k++) begin
            own[k]  = -1;
            when[k] = -1;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req0_i   = 1'b1;
                req1_i   = 1'b1;
                pready_i = 1'b1;
                prdata_i = 32'h5555_AAAA;
            end
            #1;
            if (done0_o && done1_o) both++;
            if (c >= 1 && dn < 4 && !psel_o) gaps++;
            if ((done0_o || done1_o) && dn < 4) begin
                own[dn]  = done1_o ? 1 : 0;
                when[dn] = c;
                dn++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr owner%0d", k), own[k],  k % 2);
            check($sformatf("rr cycle%0d", k), when[k], 2 + 2 * k);
        end
        check("rr idle gaps", gaps, 0);
        check("rr dual done", both, 0);

        // ---------------- timeout ----------------
        apply_reset();
        @(negedge clk);
        req0_i   = 1'b1;
        pready_i = 1'b0;
        prdata_i = 32'hCAFE_BABE;
        #1;
        acc = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (penable_o) acc++;
            if (done0_o || done1_o) begin
                seen = 1'b1;
                check("timeout done0", done0_o, 1'b1);
                check("timeout err",   err_o,   1'b1);
                check("timeout rdata", rdata_o, 32'h0);
                check("timeout access cycles", acc, TIMEOUT);
            end
        end
        if (!seen) check("timeout done seen", seen, 1'b1);
        @(negedge clk);
        req0_i = 1'b0;
        #1;
        check("timeout then idle", psel_o, 1'b0);

        // ---------------- reset mid-ACCESS ----------------
        apply_reset();
        @(negedge clk);
        req1_i   = 1'b1;
        pready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midreset in access", penable_o, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset psel",   psel_o,    1'b0);
        check("midreset penable",penable_o, 1'b0);
        check("midreset done1",  done1_o,   1'b0);
        check("midreset paddr",  paddr_o,   32'h0);
        @(negedge clk);
        req0_i   = 1'b1;
        pready_i = 1'b1;
        #1;
        check("midreset held no done", {done0_o, done1_o}, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        first_done(who);
        check("post reset tie winner", who, 0);

        apply_reset();
        @(negedge clk);
        req1_i   = 1'b1;
        pready_i = 1'b1;
        #1;
        first_done(who);
        check("post reset lone req1", who, 1);

        // ---------------- randomized traffic vs reference model ----------------
        apply_reset();
        m_busy = 1'b0; m_acc = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_wr = 1'b0; m_wait = 0; m_addr = '0; m_wdata = '0;
        hang = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            req0_i    = ($urandom_range(0, 3) != 0);
            req1_i    = ($urandom_range(0, 3) != 0);
            addr0_i   = $urandom;
            addr1_i   = $urandom;
            wdata0_i  = $urandom;
            wdata1_i  = $urandom;
            write0_i  = ($urandom_range(0, 1) != 0);
            write1_i  = ($urandom_range(0, 1) != 0);
            pslverr_i = ($urandom_range(0, 3) == 0);
            prdata_i  = $urandom;
            if (hang == 0 && $urandom_range(0, 99) < 3) hang = int'($urandom_range(14, 20));
            if (hang > 0) begin
                pready_i = 1'b0;
                hang--;
            end else begin
                pready_i = ($urandom_range(0, 1) != 0);
            end
            #1;

            finish = m_acc && (pready_i || m_wait == TIMEOUT - 1);
            e_d0   = finish && !m_owner;
            e_d1   = finish &&  m_owner;
            e_err  = finish && (!pready_i || pslverr_i);
            e_rd   = (finish && pready_i && !m_wr) ? prdata_i : 32'h0;

            check("rand psel",    psel_o,    m_busy);
            check("rand penable", penable_o, m_acc);
            check("rand done0",   done0_o,   e_d0);
            check("rand done1",   done1_o,   e_d1);
            check("rand err",     err_o,     e_err);
            check("rand rdata",   rdata_o,   e_rd);
            if (m_busy) begin
                check("rand paddr",  paddr_o,  m_addr);
                check("rand pwrite", pwrite_o, m_wr);
                check("rand pwdata", pwdata_o, m_wdata);
            end

            if (!m_busy || finish) begin
                cand0 = req0_i && !(finish && !m_owner);
                cand1 = req1_i && !(finish &&  m_owner);
                if (cand0 || cand1) begin
                    w       = (cand0 && cand1) ? !m_last : cand1;
                    m_owner = w;
                    m_last  = w;
                    m_addr  = w ? addr1_i  : addr0_i;
                    m_wdata = w ? wdata1_i : wdata0_i;
                    m_wr    = w ? write1_i : write0_i;
                    m_busy  = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
                m_acc = 1'b0;
            end else if (!m_acc) begin
                m_acc  = 1'b1;
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
